// File: rtl/character_move.sv
// Player-character position controller: walk / climb / jump / fall FSM that
// advances the registered character position once per frame tick.
module character_move #(
  parameter logic [11:0] X_INIT     = 12'd64,
  parameter logic [11:0] Y_INIT     = 12'd704,
  parameter logic [11:0] X_MAX      = 12'd960,
  parameter logic [7:0]  JUMP_TICKS = 8'd16,
  parameter logic [11:0] JUMP_STEP  = 12'd2,
  parameter logic [11:0] FALL_STEP  = 12'd2,
  parameter logic [2:0]  RAMP_DIV   = 3'd7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        left,
  input  logic        right,
  input  logic        up,
  input  logic        down,
  input  logic        jump,
  input  logic        ladder,
  input  logic [1:0]  ramp,
  input  logic [11:0] limit_ypos_min,
  input  logic [11:0] limit_ypos_max,
  input  logic        end_of_ramp,
  input  logic [11:0] landing_ypos,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        climbing,
  output logic        jumping,
  output logic        falling,
  output logic        facing_left
);

  typedef enum logic [2:0] {
    S_WALK,
    S_CLIMB,
    S_JUMP_UP,
    S_JUMP_DOWN,
    S_FALL
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] xpos_q, xpos_d;
  logic [11:0] ypos_q, ypos_d;
  logic [11:0] base_y_q, base_y_d;
  logic [2:0]  slope_q, slope_d;
  logic [7:0]  jcnt_q, jcnt_d;
  logic        prev_jump_q, prev_jump_d;
  logic        facing_left_q, facing_left_d;
  logic        climbing_q, climbing_d;
  logic        jumping_q, jumping_d;
  logic        falling_q, falling_d;

  // Decoded key intent: opposing keys cancel each other.
  logic h_left, h_right, h_any, v_up, v_down, jump_rise;
  assign h_left    = left & ~right;
  assign h_right   = right & ~left;
  assign h_any     = left ^ right;
  assign v_up      = up & ~down;
  assign v_down    = down & ~up;
  assign jump_rise = jump & ~prev_jump_q;

  // Candidate positions; every one is saturated so the registers never wrap.
  logic [11:0] x_step;
  logic        x_moved;
  logic [11:0] y_minus1, y_plus1;
  logic [11:0] y_climb_up, y_climb_down;
  logic [11:0] y_jump_up, y_jump_down, y_fall;
  logic [12:0] jump_down_sum, fall_sum;
  logic        ramp_active, ramp_rise, slope_wrap, at_limit;

  always_comb begin
    if (h_right)     x_step = (xpos_q >= X_MAX) ? X_MAX : xpos_q + 12'd1;
    else if (h_left) x_step = (xpos_q == 12'd0) ? 12'd0 : xpos_q - 12'd1;
    else             x_step = xpos_q;
  end

  assign x_moved      = (x_step != xpos_q);
  assign y_minus1     = (ypos_q == 12'd0)    ? 12'd0    : ypos_q - 12'd1;
  assign y_plus1      = (ypos_q == 12'hFFF)  ? 12'hFFF  : ypos_q + 12'd1;
  assign y_climb_up   = (ypos_q > limit_ypos_min) ? ypos_q - 12'd1 : limit_ypos_min;
  assign y_climb_down = (ypos_q < limit_ypos_max) ? ypos_q + 12'd1 : limit_ypos_max;
  assign y_jump_up    = (ypos_q >= JUMP_STEP) ? ypos_q - JUMP_STEP : 12'd0;

  assign jump_down_sum = {1'b0, ypos_q} + {1'b0, JUMP_STEP};
  assign y_jump_down   = (jump_down_sum >= {1'b0, base_y_q}) ? base_y_q : jump_down_sum[11:0];
  assign fall_sum      = {1'b0, ypos_q} + {1'b0, FALL_STEP};
  assign y_fall        = (fall_sum >= {1'b0, landing_ypos}) ? landing_ypos : fall_sum[11:0];

  // Ramp 01 climbs when walking right; ramp 10 climbs when walking left.
  assign ramp_active = (ramp == 2'b01) || (ramp == 2'b10);
  assign ramp_rise   = ((ramp == 2'b01) && h_right) || ((ramp == 2'b10) && h_left);
  assign slope_wrap  = (slope_q == RAMP_DIV);
  assign at_limit    = (ypos_q == limit_ypos_min) || (ypos_q == limit_ypos_max);

  always_comb begin
    // NOTE: every *_d gets its hold value first, so no path through the
    // case below can leave a signal unassigned and infer a latch.
    state_d       = state_q;
    xpos_d        = xpos_q;
    ypos_d        = ypos_q;
    base_y_d      = base_y_q;
    slope_d       = slope_q;
    jcnt_d        = jcnt_q;
    prev_jump_d   = prev_jump_q;
    facing_left_d = facing_left_q;

    if (tick) begin
      prev_jump_d = jump;
      unique case (state_q)
        S_WALK: begin
          if (!ramp_active) slope_d = 3'd0;
          if (end_of_ramp && (ypos_q < landing_ypos)) begin
            state_d = S_FALL;
          end else if (ladder && (up ^ down)) begin
            state_d = S_CLIMB;
          end else if (jump_rise) begin
            state_d  = S_JUMP_UP;
            base_y_d = ypos_q;
            jcnt_d   = JUMP_TICKS;
          end else begin
            xpos_d = x_step;
            if (h_any) facing_left_d = h_left;
            if (ramp_active && x_moved) begin
              slope_d = slope_wrap ? 3'd0 : slope_q + 3'd1;
              if (slope_wrap) ypos_d = ramp_rise ? y_minus1 : y_plus1;
            end
          end
        end

        S_CLIMB: begin
          if (!ladder || (at_limit && h_any)) begin
            state_d = S_WALK;
          end else if (v_up) begin
            ypos_d = y_climb_up;
          end else if (v_down) begin
            ypos_d = y_climb_down;
          end
        end

        S_JUMP_UP: begin
          ypos_d = y_jump_up;
          xpos_d = x_step;
          if (h_any) facing_left_d = h_left;
          if (jcnt_q <= 8'd1) begin
            jcnt_d  = JUMP_TICKS;
            state_d = S_JUMP_DOWN;
          end else begin
            jcnt_d = jcnt_q - 8'd1;
          end
        end

        S_JUMP_DOWN: begin
          xpos_d = x_step;
          if (h_any) facing_left_d = h_left;
          if ((jcnt_q <= 8'd1) || (y_jump_down == base_y_q)) begin
            ypos_d  = base_y_q;
            jcnt_d  = 8'd0;
            state_d = end_of_ramp ? S_FALL : S_WALK;
          end else begin
            ypos_d = y_jump_down;
            jcnt_d = jcnt_q - 8'd1;
          end
        end

        S_FALL: begin
          ypos_d = y_fall;
          if (y_fall == landing_ypos) begin
            state_d = S_WALK;
            slope_d = 3'd0;
          end
        end

        default: state_d = S_WALK;
      endcase
    end
  end

  // Flags are registered alongside the state so they line up with xpos/ypos.
  assign climbing_d = (state_d == S_CLIMB);
  assign jumping_d  = (state_d == S_JUMP_UP) || (state_d == S_JUMP_DOWN);
  assign falling_d  = (state_d == S_FALL);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_WALK;
      xpos_q        <= X_INIT;
      ypos_q        <= Y_INIT;
      base_y_q      <= 12'd0;
      slope_q       <= 3'd0;
      jcnt_q        <= 8'd0;
      prev_jump_q   <= 1'b0;
      facing_left_q <= 1'b0;
      climbing_q    <= 1'b0;
      jumping_q     <= 1'b0;
      falling_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      xpos_q        <= xpos_d;
      ypos_q        <= ypos_d;
      base_y_q      <= base_y_d;
      slope_q       <= slope_d;
      jcnt_q        <= jcnt_d;
      prev_jump_q   <= prev_jump_d;
      facing_left_q <= facing_left_d;
      climbing_q    <= climbing_d;
      jumping_q     <= jumping_d;
      falling_q     <= falling_d;
    end
  end

  assign xpos        = xpos_q;
  assign ypos        = ypos_q;
  assign climbing    = climbing_q;
  assign jumping     = jumping_q;
  assign falling     = falling_q;
  assign facing_left = facing_left_q;

endmodule

// File: tb/tb_character_move.sv
// Bench for character_move: directed scenarios plus random stimulus, all
// checked against a behavioural model of the movement rules.
module tb_character_move;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0, jump = 1'b0;
  logic        ladder = 1'b0;
  logic [1:0]  ramp = 2'b00;
  logic [11:0] limit_ypos_min = 12'd0;
  logic [11:0] limit_ypos_max = 12'd0;
  logic        end_of_ramp = 1'b0;
  logic [11:0] landing_ypos = 12'd0;
  logic [11:0] xpos, ypos;
  logic        climbing, jumping, falling, facing_left;

  character_move dut (
    .clk(clk), .rst(rst), .tick(tick),
    .left(left), .right(right), .up(up), .down(down), .jump(jump),
    .ladder(ladder), .ramp(ramp),
    .limit_ypos_min(limit_ypos_min), .limit_ypos_max(limit_ypos_max),
    .end_of_ramp(end_of_ramp), .landing_ypos(landing_ypos),
    .xpos(xpos), .ypos(ypos),
    .climbing(climbing), .jumping(jumping), .falling(falling),
    .facing_left(facing_left)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: plain integers, one call per tick.
  typedef enum {M_WALK, M_CLIMB, M_RISE, M_DESCEND, M_FALL} mode_t;
  mode_t m_mode;
  int    m_x, m_y, m_base, m_slope, m_jc;
  bit    m_prev, m_face;

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    m_mode = M_WALK; m_x = 64; m_y = 704; m_base = 0;
    m_slope = 0; m_jc = 0; m_prev = 0; m_face = 0;
  endtask

  task automatic model_tick();
    int dx, nx, dy, lmin, lmax, land, rmp;
    dx   = (right && !left) ? 1 : ((left && !right) ? -1 : 0);
    lmin = int'(limit_ypos_min);
    lmax = int'(limit_ypos_max);
    land = int'(landing_ypos);
    rmp  = int'(ramp);
    case (m_mode)
      M_WALK: begin
        if (rmp == 0 || rmp == 3) m_slope = 0;
        if (end_of_ramp && m_y < land) m_mode = M_FALL;
        else if (ladder && (up != down)) m_mode = M_CLIMB;
        else if (jump && !m_prev) begin
          m_mode = M_RISE; m_base = m_y; m_jc = 16;
        end else begin
          nx = clampi(m_x + dx, 0, 960);
          if (dx != 0) m_face = (dx < 0);
          if ((rmp == 1 || rmp == 2) && nx != m_x) begin
            m_slope++;
            if (m_slope == 8) begin
              m_slope = 0;
              dy = (rmp == 1) ? -dx : dx;
              m_y = clampi(m_y + dy, 0, 4095);
            end
          end
          m_x = nx;
        end
      end
      M_CLIMB: begin
        if (!ladder || ((m_y == lmin || m_y == lmax) && left != right)) m_mode = M_WALK;
        else if (up && !down) m_y = (m_y - 1 < lmin) ? lmin : m_y - 1;
        else if (down && !up) m_y = (m_y + 1 > lmax) ? lmax : m_y + 1;
      end
      M_RISE: begin
        m_y = clampi(m_y - 2, 0, 4095);
        m_x = clampi(m_x + dx, 0, 960);
        if (dx != 0) m_face = (dx < 0);
        m_jc--;
        if (m_jc == 0) begin m_jc = 16; m_mode = M_DESCEND; end
      end
      M_DESCEND: begin
        m_y = (m_y + 2 > m_base) ? m_base : m_y + 2;
        m_x = clampi(m_x + dx, 0, 960);
        if (dx != 0) m_face = (dx < 0);
        m_jc--;
        if (m_jc == 0 || m_y == m_base) begin
          m_y = m_base;
          m_mode = end_of_ramp ? M_FALL : M_WALK;
        end
      end
      M_FALL: begin
        m_y = (m_y + 2 > land) ? land : m_y + 2;
        if (m_y == land) begin m_mode = M_WALK; m_slope = 0; end
      end
      default: m_mode = M_WALK;
    endcase
    m_prev = jump;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".xpos"},     32'(xpos),        32'(m_x));
    check({tag, ".ypos"},     32'(ypos),        32'(m_y));
    check({tag, ".climbing"}, 32'(climbing),    32'(m_mode == M_CLIMB));
    check({tag, ".jumping"},  32'(jumping),     32'(m_mode == M_RISE || m_mode == M_DESCEND));
    check({tag, ".falling"},  32'(falling),     32'(m_mode == M_FALL));
    check({tag, ".facing"},   32'(facing_left), 32'(m_face));
  endtask

  // One tick cycle, then `idle` quiet cycles; outputs sampled on negedges.
  task automatic step(input string tag, input int idle);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    model_tick();
    repeat (idle) @(negedge clk);
    check_model(tag);
  endtask

  task automatic do_reset(input bit with_tick);
    @(negedge clk); rst = 1'b0; tick = with_tick;
    @(negedge clk); rst = 1'b1; tick = 1'b0;
    model_reset();
    check_model("reset");
  endtask

  task automatic clear_keys();
    left = 0; right = 0; up = 0; down = 0; jump = 0;
    ladder = 0; ramp = 2'b00; end_of_ramp = 0;
  endtask

  initial begin
    int jump_ticks, y_min;
    model_reset();
    repeat (3) @(negedge clk);
    do_reset(1'b0);
    check("reset_x", 32'(xpos), 32'd64);
    check("reset_y", 32'(ypos), 32'd704);
    check("reset_flags", 32'({climbing, jumping, falling, facing_left}), 32'd0);

    // Walk right on flat ground.
    right = 1;
    for (int i = 0; i < 10; i++) step("walk_r", i % 2);
    check("walk10_x", 32'(xpos), 32'd74);
    check("walk10_y", 32'(ypos), 32'd704);

    // Climb from 704 up to 600, then 600 -> 400 with new limits.
    clear_keys();
    ladder = 1; up = 1; limit_ypos_min = 12'd600; limit_ypos_max = 12'd704;
    for (int i = 0; i < 110; i++) step("climb_a", 0);
    check("climb_at600", 32'(ypos), 32'd600);
    limit_ypos_min = 12'd400; limit_ypos_max = 12'd600;
    for (int i = 0; i < 250; i++) step("climb_b", 0);
    check("climb_at400", 32'(ypos), 32'd400);
    check("climb_flag", 32'(climbing), 32'd1);
    ladder = 0;
    step("climb_exit", 0);
    check("climb_exit_flag", 32'(climbing), 32'd0);

    // Down to 500, then leave at the bottom limit with a side key.
    ladder = 1; up = 0; down = 1; limit_ypos_max = 12'd500;
    for (int i = 0; i < 110; i++) step("climb_dn", 1);
    check("climb_at500", 32'(ypos), 32'd500);
    down = 0; right = 1;
    step("climb_side_exit", 0);
    check("side_exit_x", 32'(xpos), 32'd74);
    check("side_exit_flag", 32'(climbing), 32'd0);
    ladder = 0;
    for (int i = 0; i < 26; i++) step("walk_to100", 0);
    check("at100_x", 32'(xpos), 32'd100);

    // Ramps.
    ramp = 2'b01;
    for (int i = 0; i < 16; i++) step("ramp01_r", 0);
    check("ramp01_x", 32'(xpos), 32'd116);
    check("ramp01_y", 32'(ypos), 32'd498);
    ramp = 2'b10; right = 0; left = 1;
    for (int i = 0; i < 8; i++) step("ramp10_l", 0);
    check("ramp10_facing", 32'(facing_left), 32'd1);

    // Jump from 704 with jump held throughout.
    do_reset(1'b1);
    clear_keys();
    jump = 1; jump_ticks = 0; y_min = 4095;
    for (int i = 0; i < 40; i++) begin
      step("jump", 0);
      if (jumping) jump_ticks++;
      if (int'(ypos) < y_min) y_min = int'(ypos);
    end
    check("jump_ticks", 32'(jump_ticks), 32'd32);
    check("jump_min_y", 32'(y_min), 32'd672);
    check("jump_end_y", 32'(ypos), 32'd704);

    // Reach 600 by ladder, then fall to 620.
    clear_keys();
    step("jump_release", 0);
    ladder = 1; up = 1; limit_ypos_min = 12'd600; limit_ypos_max = 12'd704;
    for (int i = 0; i < 110; i++) step("climb_c", 0);
    clear_keys();
    step("climb_c_exit", 0);
    end_of_ramp = 1; landing_ypos = 12'd620;
    step("fall_enter", 0);
    check("fall_enter_flag", 32'(falling), 32'd1);
    end_of_ramp = 0;
    for (int k = 1; k <= 10; k++) begin
      step("fall", 0);
      check("fall_y", 32'(ypos), 32'(600 + 2 * k));
    end
    check("fall_done_flag", 32'(falling), 32'd0);

    // Reset together with a tick in the middle of a fall.
    end_of_ramp = 1; landing_ypos = 12'd700;
    for (int i = 0; i < 4; i++) step("fall2", 0);
    check("fall2_flag", 32'(falling), 32'd1);
    do_reset(1'b1);
    check("midfall_rst_x", 32'(xpos), 32'd64);
    check("midfall_rst_y", 32'(ypos), 32'd704);
    check("midfall_rst_flags", 32'({climbing, jumping, falling, facing_left}), 32'd0);

    // Horizontal clamps.
    clear_keys();
    left = 1;
    for (int i = 0; i < 70; i++) step("clamp_l", 0);
    check("clamp_x0", 32'(xpos), 32'd0);
    left = 0; right = 1;
    for (int i = 0; i < 970; i++) step("clamp_r", 0);
    check("clamp_xmax", 32'(xpos), 32'd960);

    // Random stimulus against the model.
    for (int i = 0; i < 2000; i++) begin
      left           = ($urandom_range(0, 99) < 40);
      right          = ($urandom_range(0, 99) < 40);
      up             = ($urandom_range(0, 99) < 30);
      down           = ($urandom_range(0, 99) < 30);
      jump           = ($urandom_range(0, 99) < 20);
      ladder         = ($urandom_range(0, 99) < 30);
      ramp           = 2'($urandom_range(0, 3));
      end_of_ramp    = ($urandom_range(0, 99) < 15);
      limit_ypos_min = 12'(clampi(m_y - int'($urandom_range(0, 40)), 0, 4095));
      limit_ypos_max = 12'(clampi(m_y + int'($urandom_range(0, 40)), 0, 4095));
      landing_ypos   = 12'(clampi(m_y + int'($urandom_range(0, 80)) - 20, 0, 4095));
      if ($urandom_range(0, 199) == 0) do_reset(1'($urandom_range(0, 1)));
      else step("rand", int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
